// File: rtl/image_load_sequencer_if.sv
// rtl/image_load_sequencer_if.sv - ROM read port and BRAM write ports of the image load sequencer
interface image_load_sequencer_if #(
  parameter int ROM_AW = 16
);
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              imem_we;
  logic [8:0]        imem_addr;
  logic [15:0]       imem_wdata;
  logic              hash_we;
  logic [3:0]        hash_addr;
  logic [255:0]      hash_wdata;
  logic              enc_we;
  logic [4:0]        enc_addr;
  logic [127:0]      enc_wdata;
  logic              dec_we;
  logic [4:0]        dec_addr;
  logic [127:0]      dec_wdata;

  modport master (
    output rom_addr,
    input  rom_data,
    output imem_we, imem_addr, imem_wdata,
    output hash_we, hash_addr, hash_wdata,
    output enc_we, enc_addr, enc_wdata,
    output dec_we, dec_addr, dec_wdata
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  imem_we, imem_addr, imem_wdata,
    input  hash_we, hash_addr, hash_wdata,
    input  enc_we, enc_addr, enc_wdata,
    input  dec_we, dec_addr, dec_wdata
  );
endinterface

// File: rtl/image_load_sequencer.sv
// rtl/image_load_sequencer.sv - walks a framed boot ROM image into IMEM/HASH/ENC/DEC BRAMs, verifies checksum
module image_load_sequencer #(
  parameter int ROM_AW      = 16,
  parameter int IMEM_DEPTH  = 512,
  parameter int HASH_DEPTH  = 16,
  parameter int CRYPT_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          go,
  image_load_sequencer_if.master        bus,
  output logic                          busy,
  output logic                          cpu_start,
  output logic                          error,
  output logic [1:0]                    err_code
);

  typedef enum logic [2:0] {IDLE, HDR, BASE, LOAD, CSUM, DONE, ERR} state_t;

  state_t        state;
  logic [3:0]    target;
  logic [11:0]   ent_cnt;
  logic [3:0]    word_cnt;
  logic [15:0]   cur_addr;
  logic [255:0]  pack;
  logic [15:0]   csum;

  logic [15:0]   w;
  logic [3:0]    last_word;
  logic [16:0]   depth;
  logic [16:0]   span;
  logic [255:0]  pack_next;
  logic          wrapped;

  assign w    = bus.rom_data;
  assign span = {1'b0, w} + {5'b0, ent_cnt};
  // rom_addr only returns to 0 while busy when the word at the top address is being consumed
  assign wrapped = (bus.rom_addr == '0);

  always_comb begin
    last_word = 4'd7;
    depth     = 17'(CRYPT_DEPTH);
    pack_next = {128'b0, w, pack[127:16]};
    case (target)
      4'h0: begin
        last_word = 4'd0;
        depth     = 17'(IMEM_DEPTH);
        pack_next = {240'b0, w};
      end
      4'h1: begin
        last_word = 4'd15;
        depth     = 17'(HASH_DEPTH);
        pack_next = {w, pack[255:16]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      target         <= '0;
      ent_cnt        <= '0;
      word_cnt       <= '0;
      cur_addr       <= '0;
      pack           <= '0;
      csum           <= '0;
      busy           <= 1'b0;
      cpu_start      <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
      bus.rom_addr   <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.hash_we    <= 1'b0;
      bus.hash_addr  <= '0;
      bus.hash_wdata <= '0;
      bus.enc_we     <= 1'b0;
      bus.enc_addr   <= '0;
      bus.enc_wdata  <= '0;
      bus.dec_we     <= 1'b0;
      bus.dec_addr   <= '0;
      bus.dec_wdata  <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      bus.hash_we <= 1'b0;
      bus.enc_we  <= 1'b0;
      bus.dec_we  <= 1'b0;
      case (state)
        IDLE, ERR: begin
          // word 0 is already being read because rom_addr sits at 0 while waiting
          if (go) begin
            state        <= HDR;
            busy         <= 1'b1;
            error        <= 1'b0;
            err_code     <= 2'd0;
            csum         <= '0;
            bus.rom_addr <= 1;
          end
        end
        HDR: begin
          bus.rom_addr <= bus.rom_addr + 1'b1;
          csum         <= csum ^ w;
          target       <= w[15:12];
          ent_cnt      <= w[11:0];
          if (wrapped) begin
            state <= ERR; busy <= 1'b0; error <= 1'b1; err_code <= 2'd2; bus.rom_addr <= '0;
          end else if (w[15:12] == 4'hF) begin
            state <= CSUM;
          end else if (w[15:12] > 4'h3) begin
            state <= ERR; busy <= 1'b0; error <= 1'b1; err_code <= 2'd1; bus.rom_addr <= '0;
          end else begin
            state <= BASE;
          end
        end
        BASE: begin
          bus.rom_addr <= bus.rom_addr + 1'b1;
          csum         <= csum ^ w;
          cur_addr     <= w;
          word_cnt     <= '0;
          if (wrapped || span > depth) begin
            state <= ERR; busy <= 1'b0; error <= 1'b1; err_code <= 2'd2; bus.rom_addr <= '0;
          end else if (ent_cnt == '0) begin
            state <= HDR;
          end else begin
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.rom_addr <= bus.rom_addr + 1'b1;
          csum         <= csum ^ w;
          pack         <= pack_next;
          if (wrapped) begin
            state <= ERR; busy <= 1'b0; error <= 1'b1; err_code <= 2'd2; bus.rom_addr <= '0;
          end else if (word_cnt == last_word) begin
            word_cnt <= '0;
            cur_addr <= cur_addr + 1'b1;
            ent_cnt  <= ent_cnt - 1'b1;
            case (target)
              4'h0: begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= cur_addr[8:0];
                bus.imem_wdata <= pack_next[15:0];
              end
              4'h1: begin
                bus.hash_we    <= 1'b1;
                bus.hash_addr  <= cur_addr[3:0];
                bus.hash_wdata <= pack_next;
              end
              4'h2: begin
                bus.enc_we     <= 1'b1;
                bus.enc_addr   <= cur_addr[4:0];
                bus.enc_wdata  <= pack_next[127:0];
              end
              default: begin
                bus.dec_we     <= 1'b1;
                bus.dec_addr   <= cur_addr[4:0];
                bus.dec_wdata  <= pack_next[127:0];
              end
            endcase
            if (ent_cnt == 12'd1) state <= HDR;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        CSUM: begin
          bus.rom_addr <= '0;
          busy         <= 1'b0;
          if (w == csum) begin
            state     <= DONE;
            cpu_start <= 1'b1;
          end else begin
            state <= ERR; error <= 1'b1; err_code <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_image_load_sequencer.sv
// tb/tb_image_load_sequencer.sv - directed bench for image_load_sequencer
module tb_image_load_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       busy, cpu_start, error;
  logic [1:0] err_code;

  image_load_sequencer_if #(.ROM_AW(16)) ifc ();

  image_load_sequencer #(
    .ROM_AW(16), .IMEM_DEPTH(512), .HASH_DEPTH(16), .CRYPT_DEPTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .bus(ifc.master),
    .busy(busy), .cpu_start(cpu_start), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  always @(posedge clk)
    ifc.rom_data <= (ifc.rom_addr < 16'd256) ? rom[ifc.rom_addr[7:0]] : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           imem_n = 0, hash_n = 0, enc_n = 0, dec_n = 0, dbl_n = 0;
  logic [8:0]   imem_a [0:63];
  logic [15:0]  imem_d [0:63];
  int           imem_c [0:63];
  logic [3:0]   hash_a [0:15];
  logic [255:0] hash_d [0:15];
  logic [4:0]   enc_a  [0:15];
  logic [127:0] enc_d  [0:15];
  logic [4:0]   dec_a  [0:15];
  logic [127:0] dec_d  [0:15];

  always @(negedge clk) begin
    if (32'(ifc.imem_we) + 32'(ifc.hash_we) + 32'(ifc.enc_we) + 32'(ifc.dec_we) > 1) dbl_n <= dbl_n + 1;
    if (ifc.imem_we) begin
      imem_a[imem_n[5:0]] <= ifc.imem_addr; imem_d[imem_n[5:0]] <= ifc.imem_wdata;
      imem_c[imem_n[5:0]] <= cyc; imem_n <= imem_n + 1;
    end
    if (ifc.hash_we) begin
      hash_a[hash_n[3:0]] <= ifc.hash_addr; hash_d[hash_n[3:0]] <= ifc.hash_wdata; hash_n <= hash_n + 1;
    end
    if (ifc.enc_we) begin
      enc_a[enc_n[3:0]] <= ifc.enc_addr; enc_d[enc_n[3:0]] <= ifc.enc_wdata; enc_n <= enc_n + 1;
    end
    if (ifc.dec_we) begin
      dec_a[dec_n[3:0]] <= ifc.dec_addr; dec_d[dec_n[3:0]] <= ifc.dec_wdata; dec_n <= dec_n + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int wp;
  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    wp = 0;
  endtask
  task automatic put(input logic [15:0] v);
    rom[wp] = v;
    wp++;
  endtask
  task automatic put_end();
    logic [15:0] x;
    x = 16'hF000;
    for (int i = 0; i < wp; i++) x = x ^ rom[i];
    put(16'hF000);
    put(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_wait();
    int n;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    n = 0;
    while (!(cpu_start || error) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!(cpu_start || error)) check("timeout", 256'd0, 256'd1);
  endtask

  int i0, h0, e0, d0;
  logic [255:0] exp;

  initial begin
    rom_clear();
    #1;
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_cpu_start", 256'(cpu_start), 256'd0);
    check("rst_error", 256'({error, err_code}), 256'd0);
    check("rst_rom_addr", 256'(ifc.rom_addr), 256'd0);
    check("rst_strobes", 256'({ifc.imem_we, ifc.hash_we, ifc.enc_we, ifc.dec_we}), 256'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // IMEM section of three words; checksum hand-computed as 0x5013
    put(16'h0003); put(16'h0010); put(16'hA001); put(16'hA002); put(16'hA003);
    put(16'hF000); put(16'h5013);
    i0 = imem_n;
    go_wait();
    check("imem_count", 256'(imem_n - i0), 256'd3);
    check("imem_a0", 256'(imem_a[i0]), 256'h10);
    check("imem_a1", 256'(imem_a[i0+1]), 256'h11);
    check("imem_a2", 256'(imem_a[i0+2]), 256'h12);
    check("imem_d0", 256'(imem_d[i0]), 256'hA001);
    check("imem_d1", 256'(imem_d[i0+1]), 256'hA002);
    check("imem_d2", 256'(imem_d[i0+2]), 256'hA003);
    check("imem_consecutive", 256'(imem_c[i0+2] - imem_c[i0]), 256'd2);
    check("imem_done", 256'({cpu_start, busy, error}), 256'b100);

    // HASH section, one 256-bit entry
    do_reset();
    rom_clear();
    put(16'h1001); put(16'h0002);
    for (int k = 0; k < 16; k++) put(16'(k));
    put_end();
    h0 = hash_n;
    go_wait();
    exp = '0;
    for (int k = 0; k < 16; k++) exp[16*k +: 16] = 16'(k);
    check("hash_count", 256'(hash_n - h0), 256'd1);
    check("hash_addr", 256'(hash_a[h0[3:0]]), 256'd2);
    check("hash_lo", 256'(hash_d[h0[3:0]][15:0]), 256'h0000);
    check("hash_hi", 256'(hash_d[h0[3:0]][255:240]), 256'h000F);
    check("hash_data", hash_d[h0[3:0]], exp);
    check("hash_done", 256'(cpu_start), 256'd1);

    // ENC two entries at 4, then DEC one entry at the last slot
    do_reset();
    rom_clear();
    put(16'h2002); put(16'h0004);
    for (int k = 0; k < 16; k++) put(16'h1100 + 16'(k));
    put(16'h3001); put(16'h001F);
    for (int k = 0; k < 8; k++) put(16'h2200 + 16'(k));
    put_end();
    e0 = enc_n; d0 = dec_n;
    go_wait();
    check("enc_count", 256'(enc_n - e0), 256'd2);
    check("enc_a0", 256'(enc_a[e0[3:0]]), 256'd4);
    check("enc_a1", 256'(enc_a[e0[3:0]+1]), 256'd5);
    exp = '0;
    for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'h1108 + 16'(k);
    check("enc_d1", 256'(enc_d[e0[3:0]+1]), exp);
    check("dec_count", 256'(dec_n - d0), 256'd1);
    check("dec_a0", 256'(dec_a[d0[3:0]]), 256'd31);
    exp = '0;
    for (int k = 0; k < 8; k++) exp[16*k +: 16] = 16'h2200 + 16'(k);
    check("dec_d0", 256'(dec_d[d0[3:0]]), exp);
    check("no_double_strobe", 256'(dbl_n), 256'd0);
    check("crypt_done", 256'({cpu_start, error}), 256'b10);

    // bad checksum, then repaired image restarted from ERR
    do_reset();
    rom_clear();
    put(16'h0003); put(16'h0010); put(16'hA001); put(16'hA002); put(16'hA003);
    put(16'hF000); put(16'h5014);
    go_wait();
    check("csum_err", 256'({cpu_start, error, err_code}), 256'b0111);
    rom[6] = 16'h5013;
    i0 = imem_n;
    go_wait();
    check("csum_retry", 256'({cpu_start, busy, error, err_code}), 256'b10000);
    check("csum_retry_imem", 256'(imem_n - i0), 256'd3);

    // bad target
    do_reset();
    rom_clear();
    put(16'h5001); put(16'h0000); put(16'h1234);
    put_end();
    i0 = imem_n; h0 = hash_n; e0 = enc_n; d0 = dec_n;
    go_wait();
    check("bad_target", 256'({cpu_start, error, err_code}), 256'b0101);
    check("bad_target_nowr", 256'((imem_n - i0) + (hash_n - h0) + (enc_n - e0) + (dec_n - d0)), 256'd0);

    // IMEM range overflow at the top entry
    do_reset();
    rom_clear();
    put(16'h0002); put(16'h01FF); put(16'h1111); put(16'h2222);
    put_end();
    i0 = imem_n;
    go_wait();
    check("range_err", 256'({cpu_start, error, err_code}), 256'b0110);
    check("range_nowr", 256'(imem_n - i0), 256'd0);

    // reset during a HASH entry, then full reload
    do_reset();
    rom_clear();
    put(16'h1001); put(16'h0002);
    for (int k = 0; k < 16; k++) put(16'(k));
    put_end();
    h0 = hash_n;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    repeat (8) @(negedge clk);
    check("midload_busy", 256'(busy), 256'd1);
    rst_n = 1'b0;
    #1;
    check("midload_rst_out", 256'({busy, cpu_start, error, err_code, ifc.hash_we}), 256'd0);
    check("midload_rst_addr", 256'(ifc.rom_addr), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midload_nowr", 256'(hash_n - h0), 256'd0);
    go_wait();
    exp = '0;
    for (int k = 0; k < 16; k++) exp[16*k +: 16] = 16'(k);
    check("reload_count", 256'(hash_n - h0), 256'd1);
    check("reload_data", hash_d[h0[3:0]], exp);
    check("reload_done", 256'(cpu_start), 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
